// File: rtl/add_disp_pkg.sv
// Shared constants for the adder result display: glyphs, FSM encoding,
// and the fixed result width.
package add_disp_pkg;

  localparam int RES_W = 5;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t CONV = 1'b1;

  // Active-low glyphs, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble correction for one BCD nibble.
  function automatic logic [3:0] bcd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/add_result_display_seg7.sv
// seg7_decode: combinational 4-bit BCD to active-low 7-segment glyph.
// Ports: i_bcd (digit 0..9), o_seg (gfedcba, blank for 10..15).
module seg7_decode
  import add_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/add_result_display.sv
// add_result_display: captures the 5-bit adder result on load, converts it
// to BCD with a 5-step double-dabble FSM and scans it onto a 2-digit
// common-anode display.
// Ports: clk, rst (async high), result_in, load -> busy, done, shown_val,
//        seg (active-low gfedcba), an (active-low, an[0]=ones).
// Option: define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module add_result_display
  import add_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RES_W-1:0] result_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] shown_val,
  output logic [6:0]       seg,
  output logic [1:0]       an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  state_t           r_state;
  logic [RES_W-1:0] r_bin;
  logic [RES_W-1:0] r_cap;
  logic [7:0]       r_bcd;
  logic [2:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [RES_W-1:0] r_shown;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;

  logic [7:0]       w_adj;
  logic [12:0]      w_cat;
  logic [12:0]      w_sh;

  // Adjust both nibbles, then shift {bcd, bin} left. A rotate is used so
  // no bit is left dangling; what wraps into bin is never consumed within
  // the five steps.
  assign w_adj = {bcd_adj(r_bcd[7:4]), bcd_adj(r_bcd[3:0])};
  assign w_cat = {w_adj, r_bin};
  assign w_sh  = {w_cat[11:0], w_cat[12]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_cap   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_shown <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (load) begin
            r_bin   <= result_in;
            r_cap   <= result_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_bcd <= w_sh[12:5];
          r_bin <= w_sh[4:0];
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd4) begin
            r_tens  <= w_sh[12:9];
            r_ones  <= w_sh[8:5];
            r_shown <= r_cap;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Scan: r_dig 0 = ones active, 1 = tens active.
  logic [CW-1:0] r_scan;
  logic          r_dig;
  logic [1:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_wrap;
  logic          w_dig_nxt;
  logic [3:0]    w_nib;
  logic [6:0]    w_glyph;
  logic [6:0]    w_seg_nxt;

  assign w_wrap    = (r_scan == SCAN_LAST);
  assign w_dig_nxt = w_wrap ? ~r_dig : r_dig;
  assign w_nib     = w_dig_nxt ? r_tens : r_ones;

  seg7_decode u_dec (
    .i_bcd (w_nib),
    .o_seg (w_glyph)
  );

  // seg is computed from the digit that will be active after this edge,
  // so an and seg always switch together.
  always_comb begin
    w_seg_nxt = w_glyph;
`ifdef LEADING_ZERO_BLANK_EN
    if (w_dig_nxt && (r_tens == 4'd0))
      w_seg_nxt = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_dig  <= 1'b0;
      r_an   <= 2'b10;
      r_seg  <= SEG_0;
    end else begin
      r_scan <= w_wrap ? '0 : r_scan + 1'b1;
      r_dig  <= w_dig_nxt;
      r_an   <= w_dig_nxt ? 2'b01 : 2'b10;
      r_seg  <= w_seg_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign shown_val = r_shown;
  assign seg       = r_seg;
  assign an        = r_an;

endmodule

// File: doc/add_result_display.md
Name: add_result_display

Overview:
- Downstream consumer of the 4-bit adder stage. Takes its 5-bit result {carry, sum}, ranging 0..31, on a load strobe.
- Converts the result to two BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes the digits onto a 2-digit common-anode 7-segment display.
- Sits between the adder and board I/O pins in the lab top level.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled before the scan switches digit (must be >= 2).
- RES_W, 5, result width: adder carry bit plus 4-bit sum. Fixed; not intended to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- result_in  input  5  adder result {C, sum}; bit 4 is the carry.
- load  input  1  capture request, sampled on clk.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the displayed value updates.
- shown_val  output  5  binary value currently displayed.
- seg  output  7  segment drive, active-low, seg[0]=a … seg[6]=g.
- an  output  2  digit enable, active-low; an[0]=ones digit, an[1]=tens digit.

Behaviour:
- One clock domain (clk). rst is asynchronous, active-high; all flops clear immediately on assertion.
- Reset values:
  - busy=0, done=0, shown_val=0.
  - Digit registers tens=0, ones=0.
  - Scan counter=0, an=2'b10 (ones digit active), seg=7'b1000000 (glyph "0").
  - FSM=IDLE.
- FSM states: IDLE, CONV.
- IDLE:
  - If load=1 at a rising edge: capture result_in into the shift register, clear the BCD scratch, set bit counter=0, busy=1, go to CONV.
  - Otherwise hold.
- CONV, one double-dabble step per cycle:
  - Any BCD nibble >= 5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - Increment the bit counter.
- After exactly 5 steps (the 5th CONV edge):
  - Commit scratch into tens/ones and the captured value into shown_val.
  - done=1 for that one cycle, busy=0, return to IDLE.
- Latency: load edge to display-register update is 5 cycles. busy is high for exactly 5 cycles.
- load while busy=1 is ignored; no queueing. result_in is sampled only on the accepted load edge and may change freely afterwards.
- load held high continuously: a new capture occurs on the first IDLE cycle, i.e. every 6 cycles.
- Value range: tens 0..3, ones 0..9. 31 displays "31", 30 displays "30", 0 displays "00".
- Scan:
  - The counter runs continuously, independent of the FSM.
  - At count SCAN_DIV-1 it wraps to 0 and toggles the active digit.
  - an and seg are registered and change together on the wrap edge; no ghosting cycle.
  - Digit registers updating mid-scan take effect on the next seg register update. Within the current digit's active period that is the next cycle.
- Reset asserted mid-conversion aborts it. The display returns to "00" and the next load starts cleanly.
- Segment glyphs (active-low gfedcba) for 0–9: 40,79,24,30,19,12,02,78,00,10 hex. Tens values 0–3 use the same table.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when tens==0 and the tens digit is active, seg=7'b1111111 (blank); an still scans normally. "07" shows as " 7"; "00" shows as " 0".
- Not defined: the tens digit always shows its glyph, including leading "0".

Decomposition:
- Package add_disp_pkg holds:
  - The SEG_* glyph constants (10 entries, 7 bits).
  - SEG_BLANK.
  - The FSM state typedef/encoding (IDLE=1'b0, CONV=1'b1).
  - RES_W.
- One sub-module: seg7_decode, a purely combinational 4-bit BCD to 7-bit active-low glyph decoder, used once on the muxed digit.
- Conversion FSM and scan logic stay in the top module.

Test Plan (SCAN_DIV=4 in bench):
- Reset check: assert rst mid-cycle -> immediately busy=0, done=0, shown_val=0, an=2'b10, seg=7'h40.
- Basic conversion: result_in=5'd23, load pulse -> busy high for cycles 1–5, done pulse on cycle 5, shown_val=23. Ones slot then shows seg=7'h30 ("3"); tens slot shows 7'h24 ("2").
- Adder max: result_in=5'b11110 (15+15) -> shown_val=30; tens glyph 7'h30, ones glyph 7'h40. Also result_in=31 -> "31" (7'h30 / 7'h79).
- Ignored load: load=1 with result_in=9, then load=1 with result_in=17 two cycles later while busy -> shown_val=9, only one done pulse. Held-high load -> done every 6 cycles.
- Scan timing: an toggles 10↔01 every 4 cycles; an and seg never show a mismatched digit/glyph pair on any cycle.
- Reset mid-conversion plus feature: rst during the 3rd CONV cycle -> display "00", no done. Then load 7 -> tens slot seg=7'h7F with LEADING_ZERO_BLANK_EN, 7'h40 without.
